// File: rtl/cla_seq_pkg.sv
// Shared definitions for the multi-precision CLA add sequencer.
package cla_seq_pkg;

  localparam int LIMB_W     = 64;
  localparam int MAX_WORDS  = 8;
  localparam int LIMB_CNT_W = $clog2(MAX_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/carry_lookahead_adder_64bits.sv
// 64-bit carry-lookahead adder built from 4-bit lookahead groups.
// GG/PG are the block-level generate/propagate, independent of carry_in.
module carry_lookahead_adder_64bits (
  input  logic [63:0] in0,
  input  logic [63:0] in1,
  input  logic        carry_in,
  output logic [63:0] sum,
  output logic        GG,
  output logic        PG
);

  logic [63:0] p;
  logic [63:0] g;

  assign p = in0 ^ in1;
  assign g = in0 & in1;

  // Group lookahead, group carry chain, per-bit carries and block GG/PG.
  always_comb begin : cla
    logic [15:0] grp_g;
    logic [15:0] grp_p;
    logic [16:0] grp_c;
    logic [63:0] bit_c;
    logic        blk_g;
    int unsigned b;

    grp_g = '0;
    grp_p = '0;
    grp_c = '0;
    bit_c = '0;
    blk_g = 1'b0;

    for (int unsigned j = 0; j < 16; j++) begin
      b = 4 * j;
      grp_g[j] = g[b+3] | (p[b+3] & g[b+2]) | (p[b+3] & p[b+2] & g[b+1])
               | (p[b+3] & p[b+2] & p[b+1] & g[b]);
      grp_p[j] = &p[b +: 4];
    end

    grp_c[0] = carry_in;
    for (int unsigned j = 0; j < 16; j++) begin
      grp_c[j+1] = grp_g[j] | (grp_p[j] & grp_c[j]);
      b = 4 * j;
      bit_c[b]   = grp_c[j];
      bit_c[b+1] = g[b]   | (p[b]   & bit_c[b]);
      bit_c[b+2] = g[b+1] | (p[b+1] & bit_c[b+1]);
      bit_c[b+3] = g[b+2] | (p[b+2] & bit_c[b+2]);
      blk_g      = grp_g[j] | (grp_p[j] & blk_g);
    end

    sum = p ^ bit_c;
    GG  = blk_g;
    PG  = &grp_p;
  end

endmodule

// File: rtl/cla_add_sequencer_arb.sv
// Two-way round-robin arbiter; the priority pointer moves past the winner
// whenever a grant is issued.
module cla_rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] grant
);

  // ptr names the requester that wins a tie
  logic ptr;

  // Grant selection: a lone requester wins, a tie goes to ptr.
  always_comb begin
    grant = '0;
    if (enable) begin
      if (&req) grant[ptr] = 1'b1;
      else      grant      = req;
    end
  end

  // Priority pointer update on each issued grant.
  always_ff @(posedge clk) begin
    if (rst)           ptr <= 1'b0;
    else if (grant[0]) ptr <= 1'b1;
    else if (grant[1]) ptr <= 1'b0;
  end

endmodule

// File: rtl/cla_add_sequencer.sv
// Shares one 64-bit CLA between two requesters, performing WORDS-limb adds
// LS limb first with the carry chained between limbs.
// Optional signed-overflow output: define CLA_SEQ_OVF_EN.
module cla_add_sequencer
  import cla_seq_pkg::*;
#(
  parameter int WORDS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic [LIMB_W*WORDS-1:0] req0_a,
  input  logic [LIMB_W*WORDS-1:0] req0_b,
  input  logic                    req0_cin,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic [LIMB_W*WORDS-1:0] req1_a,
  input  logic [LIMB_W*WORDS-1:0] req1_b,
  input  logic                    req1_cin,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_id,
  output logic [LIMB_W*WORDS-1:0] rsp_sum,
  output logic                    rsp_cout
`ifdef CLA_SEQ_OVF_EN
  ,
  output logic                    rsp_ovf
`endif
);

  localparam int W = LIMB_W * WORDS;

  seq_state_t            state;
  seq_state_t            next_state;
  logic [W-1:0]          a_q;
  logic [W-1:0]          b_q;
  logic                  carry_q;
  logic [LIMB_CNT_W-1:0] limb_q;
  logic [1:0]            grant;
  logic                  last_limb;
  logic [LIMB_W-1:0]     a_limb;
  logic [LIMB_W-1:0]     b_limb;
  logic [LIMB_W-1:0]     sum_limb;
  logic                  gg;
  logic                  pg;
  logic                  carry_next;

  // Grants are only offered in IDLE and never while reset is applied.
  cla_rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({req1_valid, req0_valid}),
    .enable ((state == IDLE) && !rst),
    .grant  (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  assign last_limb  = (limb_q == LIMB_CNT_W'(WORDS - 1));

  // Select the current limb of each captured operand.
  always_comb begin
    a_limb = '0;
    b_limb = '0;
    for (int unsigned k = 0; k < WORDS; k++) begin
      if (limb_q == LIMB_CNT_W'(k)) begin
        a_limb = a_q[k*LIMB_W +: LIMB_W];
        b_limb = b_q[k*LIMB_W +: LIMB_W];
      end
    end
  end

  carry_lookahead_adder_64bits u_cla (
    .in0      (a_limb),
    .in1      (b_limb),
    .carry_in (carry_q),
    .sum      (sum_limb),
    .GG       (gg),
    .PG       (pg)
  );

  assign carry_next = gg | (pg & carry_q);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic and response valid.
  always_comb begin
    next_state = state;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: if (|grant) next_state = RUN;
      RUN:  if (last_limb) next_state = DONE;
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand capture, limb stepping and response buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      limb_q   <= '0;
      rsp_id   <= 1'b0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
      rsp_ovf  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant[1]) begin
            a_q     <= req1_a;
            b_q     <= req1_b;
            carry_q <= req1_cin;
            rsp_id  <= 1'b1;
            limb_q  <= '0;
          end else if (grant[0]) begin
            a_q     <= req0_a;
            b_q     <= req0_b;
            carry_q <= req0_cin;
            rsp_id  <= 1'b0;
            limb_q  <= '0;
          end
        end
        RUN: begin
          for (int unsigned k = 0; k < WORDS; k++) begin
            if (limb_q == LIMB_CNT_W'(k)) rsp_sum[k*LIMB_W +: LIMB_W] <= sum_limb;
          end
          carry_q <= carry_next;
          if (last_limb) begin
            rsp_cout <= carry_next;
`ifdef CLA_SEQ_OVF_EN
            rsp_ovf  <= (a_q[W-1] == b_q[W-1]) && (sum_limb[LIMB_W-1] != a_q[W-1]);
`endif
          end else begin
            limb_q <= limb_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
